// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu_pkg : access-type codes, FSM states, lane/extend helpers |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_e;

  // Illegal codes report size 1 so the range arithmetic stays well-behaved.
  function automatic logic [2:0] dm_size(input logic [2:0] t);
    logic [2:0] s;
    case (t)
      DM_WORD:             s = 3'd4;
      DM_HALF, DM_HALF_U:  s = 3'd2;
      default:             s = 3'd1;
    endcase
    return s;
  endfunction

  function automatic logic dm_type_ok(input logic [2:0] t);
    return (t <= DM_BYTE_U);
  endfunction

  function automatic logic [3:0] dm_byte_en(input logic [2:0] t, input logic [1:0] lane);
    logic [3:0] be;
    case (t)
      DM_WORD:             be = 4'b1111;
      DM_HALF, DM_HALF_U:  be = lane[1] ? 4'b1100 : 4'b0011;
      default:             be = 4'b0001 << lane;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] dm_extend(input logic [31:0] w, input logic [2:0] t,
                                            input logic [1:0] lane);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? w[31:16] : w[15:0];
    b = 8'(w >> {lane, 3'b000});
    case (t)
      DM_WORD:   r = w;
      DM_HALF:   r = {{16{h[15]}}, h};
      DM_HALF_U: r = {16'h0, h};
      DM_BYTE:   r = {{24{b[7]}}, b};
      DM_BYTE_U: r = {24'h0, b};
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu_ram : DEPTH x 32 sync RAM, byte enables, registered read |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module dmem_lsu_ram #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu : load/store unit with fault decode and zero-fill engine |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_type,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              clr,
  output logic              busy
);

  localparam int              IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  dm_state_e        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ld_q, ld_d;
  logic [2:0]       type_q, type_d;
  logic [1:0]       lane_q, lane_d;

  logic             accept;
  logic             fault;
  logic [ADDR_W:0]  last_byte;
  logic             ram_we, ram_re;
  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  assign req_ready = (state_q == ST_RUN) & ~clr;
  assign busy      = (state_q == ST_CLEAR);
  assign accept    = req_valid & req_ready;

  // Carry bit kept so an access running off the top of the address space still faults.
  assign last_byte = {1'b0, req_addr} + (ADDR_W+1)'(dm_size(req_type)) - (ADDR_W+1)'(1);

  always_comb begin
    fault = 1'b0;
    if (!dm_type_ok(req_type))                                      fault = 1'b1;
    if ((req_type == DM_WORD) && (req_addr[1:0] != 2'b00))          fault = 1'b1;
    if ((req_type == DM_HALF || req_type == DM_HALF_U) && req_addr[0]) fault = 1'b1;
    if (last_byte >= LIMIT)                                         fault = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Fill engine owns the single RAM port whenever it is running.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = req_addr[IDX_W+1:2];
    ram_wdata = 32'h0;
    if (state_q == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_be   = 4'b1111;
      ram_addr = cnt_q;
    end else if (accept && !fault) begin
      if (req_we) begin
        ram_we    = 1'b1;
        ram_be    = dm_byte_en(req_type, req_addr[1:0]);
        ram_wdata = (req_type == DM_WORD) ? req_wdata :
                    (dm_size(req_type) == 3'd2) ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept & fault;
    ld_d        = accept & ~fault & ~req_we;
    type_d      = type_q;
    lane_d      = lane_q;
    if (accept) begin
      type_d = req_type;
      lane_d = req_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      type_q      <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
      type_q      <= type_d;
      lane_q      <= lane_d;
    end
  end

  dmem_lsu_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is already the registered word; lane select finishes it within the response cycle.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = ld_q ? dm_extend(ram_rdata, type_q, lane_q) : 32'h0;

endmodule
`default_nettype wire
